// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift sequencer: op codes, FSM states and step sizes.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int STEP_SMALL = 1;
  localparam int STEP_BIG   = 4;

endpackage

// File: rtl/shift_step.sv
// One shift/rotate step of the accumulator; the 4-bit step exists only when
// SHIFT_SEQ_STEP4_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc_i,
  input  op_e              op_i,
`ifdef SHIFT_SEQ_STEP4_EN
  input  logic             by4_i,
`endif
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
`ifdef SHIFT_SEQ_STEP4_EN
    if (by4_i) begin
      case (op_i)
        OP_SLL:  acc_o = {acc_i[WIDTH-5:0], 4'b0000};
        OP_SRA:  acc_o = {{4{acc_i[WIDTH-1]}}, acc_i[WIDTH-1:4]};
        OP_ROR:  acc_o = {acc_i[3:0], acc_i[WIDTH-1:4]};
        default: acc_o = acc_i;
      endcase
    end else begin
      case (op_i)
        OP_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
        OP_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
        OP_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
        default: acc_o = acc_i;
      endcase
    end
`else
    case (op_i)
      OP_SLL:  acc_o = {acc_i[WIDTH-2:0], 1'b0};
      OP_SRA:  acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      OP_ROR:  acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
      default: acc_o = acc_i;
    endcase
`endif
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Iterative shift/rotate sequencer (SLL/SRA/ROR/PASS) replacing a barrel shifter.
// Define SHIFT_SEQ_STEP4_EN to take 4-bit steps while at least 4 positions remain.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: a job is accepted on any rising edge where start && ready.
  // ready is high in IDLE and DONE, so a new job can be taken in the DONE
  // cycle with no gap; done pulses for exactly one cycle and result holds
  // its value from done until the next job's done.

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] step_acc;
`ifdef SHIFT_SEQ_STEP4_EN
  logic             step_by4;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
`ifdef SHIFT_SEQ_STEP4_EN
    .by4_i (step_by4),
`endif
    .acc_o (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef SHIFT_SEQ_STEP4_EN
    step_by4 = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_d   = a;
          op_d    = op_e'(op);
          cnt_d   = (op_e'(op) == OP_PASS) ? '0 : amt;
          state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // cnt_q is never zero here: zero-length jobs go straight to DONE.
`ifdef SHIFT_SEQ_STEP4_EN
        if (cnt_q >= SHW'(STEP_BIG)) begin
          step_by4 = 1'b1;
          cnt_d    = cnt_q - SHW'(STEP_BIG);
        end else begin
          cnt_d    = cnt_q - SHW'(STEP_SMALL);
        end
`else
        cnt_d   = cnt_q - SHW'(STEP_SMALL);
`endif
        acc_d   = step_acc;
        state_d = (cnt_d == '0) ? ST_DONE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_DONE) result_d = acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign ready     = (state_q != ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed cases plus a randomized job sweep against
// an arithmetic reference model; honours SHIFT_SEQ_STEP4_EN for latency.
module tb_shift_seq_ctrl;
  import shift_pkg::*;

  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [SHW-1:0] amt;
  logic           ready;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic [1:0]     dbg_state;

  int             n_cmp;
  int             n_err;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   last_res;
  int             last_lat;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .amt       (amt),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: shift computed directly from the amount, no stepping
  function automatic logic [W-1:0] model_result(input logic [1:0] o, input logic [W-1:0] av,
                                                input int am);
    logic [2*W-1:0] dbl;
    logic [W-1:0]   r;
    dbl = {av, av};
    case (o)
      2'b00:   r = av << am;
      2'b01:   r = $signed(av) >>> am;
      2'b10:   r = dbl[am +: W];
      default: r = av;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input int am);
    if (o == 2'b11 || am == 0) return 1;
`ifdef SHIFT_SEQ_STEP4_EN
    return am / 4 + am % 4 + 1;
`else
    return am + 1;
`endif
  endfunction

  // driver: issue one job (waiting for ready), track it to done, check it
  task automatic do_job(input logic [1:0] o, input logic [W-1:0] av, input logic [SHW-1:0] am,
                        input bit poke);
    int n;
    int lat;
    int exp_lat;
    exp_q.push_back(model_result(o, av, int'(am)));
    exp_lat = model_lat(o, int'(am));
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_accept", ready, 1);
    start = 1'b1; op = o; a = av; amt = am;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = W'($urandom); amt = SHW'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      check("busy_in_run", busy, 1);
      check("ready_low_in_run", ready, 0);
      check("result_hold_in_run", result, last_res);
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        op = 2'($urandom); a = W'($urandom); amt = SHW'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", lat, exp_lat);
    check("result", result, exp_q.pop_front());
    last_res = result;
    last_lat = lat;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle_done_low", done, 0);
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);
    check("idle_result_hold", result, last_res);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0; n_err = 0; last_res = '0; last_lat = 0;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; amt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;
    idle_cycle();

    // ROR by 1 and by 0
    do_job(2'b10, 16'h8001, 4'd1, 1'b0);
    check("ror1_result", last_res, 16'hC000);
    check("ror1_lat", last_lat, 2);
    idle_cycle();
    do_job(2'b10, 16'h8001, 4'd0, 1'b0);
    check("ror0_result", last_res, 16'h8001);
    check("ror0_lat", last_lat, 1);
    idle_cycle();

    // reset mid-RUN aborts with no done
    start = 1'b1; op = 2'b00; a = 16'h0001; amt = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    last_res = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    // longest SRA job
    do_job(2'b01, 16'h8000, 4'd15, 1'b0);
    check("sra15_result", last_res, 16'hFFFF);
`ifdef SHIFT_SEQ_STEP4_EN
    check("sra15_lat", last_lat, 7);
`else
    check("sra15_lat", last_lat, 16);
`endif
    idle_cycle();

    // start poked during RUN is ignored
    do_job(2'b00, 16'hFFFF, 4'd4, 1'b1);
    check("sll4_result", last_res, 16'hFFF0);
    idle_cycle();
    idle_cycle();
    check("sll4_hold", result, 16'hFFF0);

    // back-to-back: second job accepted in the DONE cycle
    do_job(2'b00, 16'h00FF, 4'd3, 1'b0);
    do_job(2'b11, 16'h1234, 4'd7, 1'b0);
    check("b2b_result", last_res, 16'h1234);
    check("b2b_lat", last_lat, 1);
    idle_cycle();

    // randomized sweep
    for (int j = 0; j < 2000; j++) begin
      do_job(2'($urandom), W'($urandom), SHW'($urandom_range(0, W - 1)),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) idle_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
